// File: rtl/octree_sram_pkg.sv
// Shared constants and the SRAM request record used by the Octree engines and the SRAM arbiter.
package octree_sram_pkg;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 64;
  localparam int STAT_WIDTH = 16;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;
endpackage

// File: rtl/octree_sram_arbiter_if.sv
// Requester-side handshake plus SRAM-side bus of the Octree SRAM arbiter.
// master: engines/SRAM environment; slave: the arbiter.
interface octree_sram_arbiter_if
  import octree_sram_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ-1:0]            req_we_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]            rsp_valid_o;
  logic [DATA_WIDTH-1:0]         rsp_rdata_o;
  logic                          sram_req_o;
  logic                          sram_we_o;
  logic [ADDR_WIDTH-1:0]         sram_addr_o;
  logic [DATA_WIDTH-1:0]         sram_wdata_o;
  logic [DATA_WIDTH-1:0]         sram_rdata_i;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, sram_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o,
    input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, sram_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o,
    output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o
  );
endinterface

// File: rtl/octree_rr_pick.sv
// Stateless round-robin picker: one-hot grant and binary index, rr_ptr has top priority.
// Latency: purely combinational; no backpressure of its own.
module octree_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      idx
);
  int best;

  // Winner is the valid requester with the smallest rotational distance from rr_ptr.
  always_comb begin
    best = NUM_REQ;
    idx  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (valid[j] && ((j + NUM_REQ - int'(rr_ptr)) % NUM_REQ) < best) begin
        best = (j + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
        idx  = PW'(j);
      end
    end
  end

  assign grant = (best < NUM_REQ) ? (NUM_REQ'(1) << idx) : '0;
endmodule

// File: rtl/octree_sram_arbiter.sv
// Round-robin share of one single-port SRAM among NUM_REQ engines; OCTREE_SRAM_ARB_STATS_EN adds grant/stall counters.
// Latency: grant combinational in cycle T, read response strobed in T+1 with unregistered SRAM data.
// Backpressure: requests wait on req_ready_o; responses cannot be held off.
module octree_sram_arbiter
  import octree_sram_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef OCTREE_SRAM_ARB_STATS_EN
  input  logic                          stats_clr_i,
  output logic [NUM_REQ*STAT_WIDTH-1:0] grant_cnt_o,
  output logic [STAT_WIDTH-1:0]         stall_cnt_o,
`endif
  octree_sram_arbiter_if.slave          bus
);
  localparam int PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    pick_grant;
  logic [NUM_REQ-1:0]    grant;
  logic [PW-1:0]         pick_idx;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         rd_tag;
  logic                  rd_pend;
  logic                  grant_any;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  octree_rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .valid  (bus.req_valid_i),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .idx    (pick_idx)
  );

  // Grants are suppressed while reset is held so the SRAM sees no stray access.
  assign grant     = rst_n ? pick_grant : '0;
  assign grant_any = |grant;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_we    = bus.req_we_i[i];
        sel_addr  = bus.req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.req_ready_o  = grant;
  assign bus.sram_req_o   = grant_any;
  assign bus.sram_we_o    = sel_we;
  assign bus.sram_addr_o  = sel_addr;
  assign bus.sram_wdata_o = sel_wdata;
  assign bus.rsp_rdata_o  = bus.sram_rdata_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      rd_pend <= 1'b0;
      rd_tag  <= '0;
    end else begin
      if (grant_any) begin
        rr_ptr <= (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      rd_pend <= grant_any && !sel_we;
      if (grant_any && !sel_we) begin
        rd_tag <= pick_idx;
      end
    end
  end

  always_comb begin
    bus.rsp_valid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid_o[i] = rd_pend && (rd_tag == PW'(i));
    end
  end

`ifdef OCTREE_SRAM_ARB_STATS_EN
  logic stall;
  assign stall = |(bus.req_valid_i & ~grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else if (stats_clr_i) begin
      grant_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && grant_cnt_o[i*STAT_WIDTH +: STAT_WIDTH] != '1) begin
          grant_cnt_o[i*STAT_WIDTH +: STAT_WIDTH] <= grant_cnt_o[i*STAT_WIDTH +: STAT_WIDTH] + 1'b1;
        end
      end
      if (stall && stall_cnt_o != '1) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_octree_sram_arbiter.sv
// Bench for octree_sram_arbiter: directed vector table, hand sequences, and random traffic vs a behavioural model.
module tb_octree_sram_arbiter;
  import octree_sram_pkg::*;

  localparam int N  = 3;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0]  valid;
  logic [N-1:0]  we;
  logic [AW-1:0] addr [N];
  logic [DW-1:0] wdata [N];

  octree_sram_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  assign bus.req_valid_i = valid;
  assign bus.req_we_i    = we;
  for (genvar i = 0; i < N; i++) begin : g_pack
    assign bus.req_addr_i[i*AW +: AW]  = addr[i];
    assign bus.req_wdata_i[i*DW +: DW] = wdata[i];
  end

`ifdef OCTREE_SRAM_ARB_STATS_EN
  logic            stats_clr = 1'b0;
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     stall_cnt;
`endif

  octree_sram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef OCTREE_SRAM_ARB_STATS_EN
    .stats_clr_i (stats_clr),
    .grant_cnt_o (grant_cnt),
    .stall_cnt_o (stall_cnt),
`endif
    .bus         (bus)
  );

  // Single-port SRAM with registered read data.
  logic [DW-1:0] sram_mem [1024];
  logic [DW-1:0] sram_rd;
  always @(posedge clk) begin
    if (bus.sram_req_o) begin
      if (bus.sram_we_o) sram_mem[bus.sram_addr_o] <= bus.sram_wdata_o;
      else               sram_rd <= sram_mem[bus.sram_addr_o];
    end
  end
  assign bus.sram_rdata_i = sram_rd;

  function automatic logic [63:0] pat(int a);
    logic [31:0] av;
    av = 32'(a);
    return {16'hC0DE, 6'd0, av[9:0], 32'h1234_5678 ^ av};
  endfunction

  // Reference model state: priority pointer, expected memory, pending response.
  int            m_ptr;
  logic [N-1:0]  m_rsp;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_mem [1024];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_rsp = '0;
  endtask

  // One clock of traffic: predicts the winner from the rotation rule, checks, then advances the model.
  task automatic run_cycle();
    int            g;
    int            c;
    logic [PW-1:0] gi;
    logic [N-1:0]  eg;
    logic          ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    g = -1;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (g < 0 && ((valid >> c) & N'(1)) != '0) g = c;
    end
    eg = '0; ewe = 1'b0; ea = '0; ed = '0; gi = '0;
    if (g >= 0) begin
      gi  = PW'(g);
      eg  = N'(1) << gi;
      ewe = we[gi];
      ea  = addr[gi];
      ed  = wdata[gi];
    end
    @(negedge clk);
    chk("grant",      64'(bus.req_ready_o),  64'(eg));
    chk("sram_req",   64'(bus.sram_req_o),   64'(g >= 0));
    chk("sram_we",    64'(bus.sram_we_o),    64'(ewe));
    chk("sram_addr",  64'(bus.sram_addr_o),  64'(ea));
    chk("sram_wdata", bus.sram_wdata_o,      ed);
    chk("rsp_valid",  64'(bus.rsp_valid_o),  64'(m_rsp));
    if (m_rsp != '0) chk("rsp_rdata", bus.rsp_rdata_o, m_rdata);
    m_rsp = '0;
    if (g >= 0) begin
      if (ewe) m_mem[ea] = ed;
      else begin
        m_rsp   = eg;
        m_rdata = m_mem[ea];
      end
      m_ptr = (g + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct packed {
    logic [N-1:0]            valid;
    sram_req_t [N-1:0]       req;
    logic [N-1:0]            exp_grant;
    logic [N-1:0]            exp_rsp;
    logic [63:0]             exp_rdata;
  } vec_t;

  function automatic vec_t mk(logic [N-1:0] v, logic [N-1:0] w, logic [9:0] a0, logic [9:0] a1,
                              logic [9:0] a2, logic [63:0] wd, logic [N-1:0] eg, logic [N-1:0] er,
                              logic [63:0] erd);
    vec_t r;
    r.valid     = v;
    r.req[0]    = '{we: w[0], addr: a0, wdata: wd};
    r.req[1]    = '{we: w[1], addr: a1, wdata: wd};
    r.req[2]    = '{we: w[2], addr: a2, wdata: wd};
    r.exp_grant = eg;
    r.exp_rsp   = er;
    r.exp_rdata = erd;
    return r;
  endfunction

  vec_t tbl [7];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = pat(i);
      m_mem[i]    = pat(i);
    end
    model_reset();

    // Reset held with all requesters asking for writes: nothing may leak out.
    valid = '1; we = '1;
    addr[0] = '0; addr[1] = '0; addr[2] = '0;
    wdata[0] = '0; wdata[1] = '0; wdata[2] = '0;
    @(negedge clk);
    chk("rst_ready",    64'(bus.req_ready_o), 64'd0);
    chk("rst_sram_req", 64'(bus.sram_req_o),  64'd0);
    chk("rst_sram_we",  64'(bus.sram_we_o),   64'd0);
    chk("rst_rsp",      64'(bus.rsp_valid_o), 64'd0);
    @(posedge clk);
    #1;
    valid = '0; we = '0;
    rst_n = 1'b1;
    repeat (10) run_cycle();

    // Write-then-read of 0x3FF, then requesters 0 and 2 contending with the pointer at 1.
    tbl[0] = mk(3'b010, 3'b010, 10'h000, 10'h3FF, 10'h000, 64'hDEAD_BEEF_0000_0001, 3'b010, 3'b000, 64'h0);
    tbl[1] = mk(3'b100, 3'b000, 10'h000, 10'h000, 10'h3FF, 64'h0, 3'b100, 3'b000, 64'h0);
    tbl[2] = mk(3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 64'h0, 3'b000, 3'b100, 64'hDEAD_BEEF_0000_0001);
    tbl[3] = mk(3'b001, 3'b000, 10'h010, 10'h000, 10'h030, 64'h0, 3'b001, 3'b000, 64'h0);
    tbl[4] = mk(3'b101, 3'b000, 10'h010, 10'h000, 10'h030, 64'h0, 3'b100, 3'b001, pat(10'h010));
    tbl[5] = mk(3'b101, 3'b000, 10'h010, 10'h000, 10'h030, 64'h0, 3'b001, 3'b100, pat(10'h030));
    tbl[6] = mk(3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 64'h0, 3'b000, 3'b001, pat(10'h010));
    for (int t = 0; t < 7; t++) begin
      valid    = tbl[t].valid;
      we       = {tbl[t].req[2].we, tbl[t].req[1].we, tbl[t].req[0].we};
      addr[0]  = tbl[t].req[0].addr;  addr[1]  = tbl[t].req[1].addr;  addr[2]  = tbl[t].req[2].addr;
      wdata[0] = tbl[t].req[0].wdata; wdata[1] = tbl[t].req[1].wdata; wdata[2] = tbl[t].req[2].wdata;
      @(negedge clk);
      chk($sformatf("vec%0d_grant", t),    64'(bus.req_ready_o), 64'(tbl[t].exp_grant));
      chk($sformatf("vec%0d_sram_req", t), 64'(bus.sram_req_o),  64'(|tbl[t].exp_grant));
      chk($sformatf("vec%0d_rsp", t),      64'(bus.rsp_valid_o), 64'(tbl[t].exp_rsp));
      if (tbl[t].exp_rsp != '0) chk($sformatf("vec%0d_rdata", t), bus.rsp_rdata_o, tbl[t].exp_rdata);
      @(posedge clk);
      #1;
    end
    m_mem[10'h3FF] = 64'hDEAD_BEEF_0000_0001;

    // All three reading continuously: strict rotation, one response per cycle.
    do_reset();
    valid = '1; we = '0;
    addr[0] = 10'h010; addr[1] = 10'h020; addr[2] = 10'h030;
    repeat (9) run_cycle();

    // Read in flight when reset hits: the response must vanish; first grant after reset is requester 0.
    valid = 3'b010;
    run_cycle();
    rst_n = 1'b0;
    valid = '1;
    @(negedge clk);
    chk("inflight_rsp_dropped", 64'(bus.rsp_valid_o), 64'd0);
    chk("inflight_ready_low",   64'(bus.req_ready_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run_cycle();
    run_cycle();

    // Random mixed traffic over a small address window to provoke read-after-write.
    for (int c = 0; c < 400; c++) begin
      valid    = N'($urandom);
      we       = N'($urandom) & N'($urandom);
      addr[0]  = AW'($urandom_range(0, 7));
      addr[1]  = AW'($urandom_range(0, 7));
      addr[2]  = AW'($urandom_range(0, 7));
      wdata[0] = {$urandom, $urandom};
      wdata[1] = {$urandom, $urandom};
      wdata[2] = {$urandom, $urandom};
      run_cycle();
    end

`ifdef OCTREE_SRAM_ARB_STATS_EN
    do_reset();
    valid = '1; we = '0;
    repeat (6) run_cycle();
    valid = '0;
    chk("grant_cnt", 64'(grant_cnt), 64'({16'd2, 16'd2, 16'd2}));
    chk("stall_cnt", 64'(stall_cnt), 64'd6);
    stats_clr = 1'b1;
    run_cycle();
    stats_clr = 1'b0;
    chk("grant_cnt_clr", 64'(grant_cnt), 64'd0);
    chk("stall_cnt_clr", 64'(stall_cnt), 64'd0);
`endif

    valid = '0;
    run_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
